fft_inpl_peak_search: RTL and testbench
=======================================

// Module: fft_inpl_peak_search
// PURPOSE
//  Downstream consumer of the in-place CoreFFT output port (min and MEMBUF configs).
//  Waits for OUTP_READY, drives READ_OUTP, streams one frame of POINTS bins and computes |X|^2 per bin.
//  Reports the peak bin index, peak power, frame power sum and the frame's SCALE_EXP.
//  Feeds the GNSS acquisition controller with one result per FFT frame.
// PARAMETERS
//  POINTS       256  FFT length, power of 2 (16..4096); LOGPTS = ceil_log2(POINTS)
//  WIDTH        18   FFT output sample width (two's complement, re and im)
//  EXPW         4    SCALE_EXP width; equals floor_log2(LOGPTS)+1 of the FFT instance
//  SKIP_DC      1    1: bin 0 excluded from peak search (still included in SUM_MAG)
//  TIMEOUT      1023 max cycles in READ without a DATAO_VALID beat before abort
// PORTS
//  CLK        in   1              system clock (FFT CLK)
//  NGRST      in   1              asynchronous active-low reset
//  ENABLE     in   1              level; permits starting a new frame read
//  OUTP_READY in   1              FFT result frame available
//  READ_OUTP  out  1              read request to FFT, level
//  DATAO_VALID in  1              FFT output beat valid
//  DATAO_RE   in   WIDTH          FFT output real
//  DATAO_IM   in   WIDTH          FFT output imag
//  SCALE_EXP  in   EXPW           FFT block exponent for current frame
//  PEAK_VALID out  1              one-cycle strobe: result ports updated
//  PEAK_BIN   out  LOGPTS         bin index of maximum |X|^2
//  PEAK_MAG   out  2*WIDTH        maximum |X|^2, unsigned
//  SUM_MAG    out  2*WIDTH+LOGPTS sum of |X|^2 over all POINTS bins, unsigned
//  PEAK_EXP   out  EXPW           SCALE_EXP sampled at start of frame
//  ERR        out  1              sticky: timeout or short frame; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, accumulators 0. Async assert, sync deassert handled upstream.
//  FSM: IDLE -> READ when ENABLE & OUTP_READY; READ_OUTP=1 from the cycle after entry until last beat.
//   READ: each DATAO_VALID beat increments bin counter (0..POINTS-1); beat POINTS-1 -> DRAIN, READ_OUTP=0 same edge.
//   READ: idle counter counts cycles without a beat; reaching TIMEOUT -> ERR=1, READ_OUTP=0, -> IDLE, no PEAK_VALID.
//   DRAIN: wait 3 cycles for the mag pipeline to empty -> REPORT.
//   REPORT: PEAK_* / SUM_MAG registered, PEAK_VALID=1 for exactly one cycle -> IDLE.
//  ENABLE dropped mid-frame: frame completes normally; only blocks the next IDLE->READ.
//  OUTP_READY falling in READ before last beat: ignored; beat count/timeout governs.
//  DATAO_VALID outside READ: ignored, no state change.
//  Mag pipeline (3 stages): S1 reg re,im,bin,valid; S2 re^2, im^2 signed products (2*WIDTH-1 bits each, unsigned);
//   S3 mag = re^2 + im^2 in 2*WIDTH bits (max 2^(2W-1), no overflow). Beat-to-compare latency 3 cycles.
//  Peak compare at S3 output: replace when mag > current peak (strict; ties keep lowest bin).
//   Peak register reset to 0 / bin 0 at READ entry. SKIP_DC=1: bin 0 never compared.
//   All-zero frame: PEAK_MAG=0, PEAK_BIN=0 (or 1 if SKIP_DC) -> first non-DC bin reported.
//  SUM_MAG accumulator cleared at READ entry; width 2*WIDTH+LOGPTS, never wraps.
//  PEAK_EXP latched on IDLE->READ edge; consumer scales by 2^(2*PEAK_EXP) if needed.
//  Result ports hold last value until the next REPORT.
//  Back-to-back: IDLE->READ may occur the cycle after REPORT; min throughput = POINTS+6 cycles/frame.
// STRUCTURE
//  Shared package fft_inpl_pkg: ceil_log2/floor_log2 functions, FSM state encoding (IDLE,READ,DRAIN,REPORT),
//   MAG_PIPE=3 constant.
//  Sub-module fft_inpl_mag2 (WIDTH): 3-stage |X|^2 pipeline with valid and bin-tag passthrough.
//  Top holds FSM, bin/idle counters, peak compare, accumulator; est. 200-300 lines total.
// TESTING
//  1. POINTS=256, tone at bin 5 amplitude re=1000,im=0, others 0 -> PEAK_BIN=5, PEAK_MAG=1000000, SUM_MAG=1000000.
//  2. Equal mag 400 at bins 7 and 200 -> PEAK_BIN=7 (tie keeps lowest); DC=5000 with SKIP_DC=1 -> still 7, SUM includes DC.
//  3. Full-scale re=im=-2^17 all bins -> PEAK_MAG=2^35, SUM_MAG=2^43, no wrap; PEAK_BIN=1 (SKIP_DC=1).
//  4. DATAO_VALID stops after 100 beats -> ERR=1 after TIMEOUT cycles, READ_OUTP=0, no PEAK_VALID, back to IDLE.
//  5. Two frames back-to-back, SCALE_EXP 2 then 3 -> two PEAK_VALID strobes, PEAK_EXP 2 then 3, accumulators independent.
//  6. NGRST asserted mid-READ -> all outputs 0 immediately; after release, next OUTP_READY frame reports correctly.

Source files
------------

// File: rtl/fft_inpl_pkg.sv
// Shared definitions for the in-place FFT output consumer: state encoding,
// pipeline depth and constant log2 helpers used for port sizing.
package fft_inpl_pkg;

    localparam int MAG_PIPE = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while (((1 << r) < n) && (r < 31)) r++;
        return r;
    endfunction

    function automatic int floor_log2(input int n);
        int r;
        r = 0;
        while (((2 << r) <= n) && (r < 30)) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_inpl_peak_search_if.sv
// Bundle between the FFT output port / result consumer and the peak search block.
interface fft_inpl_peak_search_if #(
    parameter int WIDTH  = 18,
    parameter int EXPW   = 4,
    parameter int LOGPTS = 8
);
    import fft_inpl_pkg::*;

    // Handshake: READ_OUTP is a level request held for the whole frame read;
    // one bin transfers on every cycle DATAO_VALID is high while READ_OUTP is
    // high (no back-pressure), and PEAK_VALID is a single-cycle strobe that
    // qualifies PEAK_BIN/PEAK_MAG/SUM_MAG/PEAK_EXP, which then hold their value.
    logic                      ENABLE;
    logic                      OUTP_READY;
    logic                      READ_OUTP;
    logic                      DATAO_VALID;
    logic signed [WIDTH-1:0]   DATAO_RE;
    logic signed [WIDTH-1:0]   DATAO_IM;
    logic [EXPW-1:0]           SCALE_EXP;
    logic                      PEAK_VALID;
    logic [LOGPTS-1:0]         PEAK_BIN;
    logic [2*WIDTH-1:0]        PEAK_MAG;
    logic [2*WIDTH+LOGPTS-1:0] SUM_MAG;
    logic [EXPW-1:0]           PEAK_EXP;
    logic                      ERR;
    state_t                    dbg_state;

    modport master (
        output ENABLE, OUTP_READY, DATAO_VALID, DATAO_RE, DATAO_IM, SCALE_EXP,
        input  READ_OUTP, PEAK_VALID, PEAK_BIN, PEAK_MAG, SUM_MAG, PEAK_EXP, ERR,
        input  dbg_state
    );

    modport slave (
        input  ENABLE, OUTP_READY, DATAO_VALID, DATAO_RE, DATAO_IM, SCALE_EXP,
        output READ_OUTP, PEAK_VALID, PEAK_BIN, PEAK_MAG, SUM_MAG, PEAK_EXP, ERR,
        output dbg_state
    );

endinterface

// File: rtl/fft_inpl_mag2.sv
// Three-stage |X|^2 pipeline: input register, squares, sum. Valid and bin
// index travel alongside the data so the compare stage needs no extra timing.
module fft_inpl_mag2 #(
    parameter int WIDTH = 18,
    parameter int BINW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat_valid,
    input  logic signed [WIDTH-1:0] re,
    input  logic signed [WIDTH-1:0] im,
    input  logic [BINW-1:0]         bin,
    output logic                    mag_valid,
    output logic [2*WIDTH-1:0]      mag,
    output logic [BINW-1:0]         mag_bin
);

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_re;
    logic signed [WIDTH-1:0] s1_im;
    logic [BINW-1:0]         s1_bin;

    logic                    s2_valid;
    logic [2*WIDTH-2:0]      s2_re2;
    logic [2*WIDTH-2:0]      s2_im2;
    logic [BINW-1:0]         s2_bin;

    logic signed [2*WIDTH-1:0] re_sq;
    logic signed [2*WIDTH-1:0] im_sq;
    logic                      unused_sign;

    // A square is never negative and peaks at 2^(2W-2), so the sign bit is dropped.
    always_comb begin
        re_sq = s1_re * s1_re;
        im_sq = s1_im * s1_im;
    end

    assign unused_sign = re_sq[2*WIDTH-1] ^ im_sq[2*WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_bin    <= '0;
            s2_valid  <= 1'b0;
            s2_re2    <= '0;
            s2_im2    <= '0;
            s2_bin    <= '0;
            mag_valid <= 1'b0;
            mag       <= '0;
            mag_bin   <= '0;
        end else begin
            s1_valid  <= beat_valid;
            s1_re     <= re;
            s1_im     <= im;
            s1_bin    <= bin;
            s2_valid  <= s1_valid;
            s2_re2    <= re_sq[2*WIDTH-2:0];
            s2_im2    <= im_sq[2*WIDTH-2:0];
            s2_bin    <= s1_bin;
            mag_valid <= s2_valid;
            mag       <= {1'b0, s2_re2} + {1'b0, s2_im2};
            mag_bin   <= s2_bin;
        end
    end

endmodule

// File: rtl/fft_inpl_peak_search.sv
// Reads one in-place FFT frame per request, tracks the strongest bin and the
// total power, and publishes one result (with the frame's block exponent) per frame.
module fft_inpl_peak_search
    import fft_inpl_pkg::*;
#(
    parameter int POINTS  = 256,
    parameter int WIDTH   = 18,
    parameter int EXPW    = 4,
    parameter int SKIP_DC = 1,
    parameter int TIMEOUT = 1023
) (
    input logic                   CLK,
    input logic                   NGRST,
    fft_inpl_peak_search_if.slave bus
);

    localparam int LOGPTS = ceil_log2(POINTS);
    localparam int MAGW   = 2 * WIDTH;
    localparam int SUMW   = MAGW + LOGPTS;
    localparam int IDLEW  = ceil_log2(TIMEOUT + 1);
    localparam logic [LOGPTS-1:0] FIRST_BIN = LOGPTS'(SKIP_DC != 0);

    state_t state_q;
    state_t state_d;

    logic [LOGPTS-1:0] bin_cnt;
    logic [IDLEW-1:0]  idle_cnt;
    logic [1:0]        drain_cnt;

    logic start;
    logic beat;
    logic last_beat;
    logic timeout;
    logic drain_done;
    logic report;
    logic in_frame;

    logic              mag_valid;
    logic [MAGW-1:0]   mag;
    logic [LOGPTS-1:0] mag_bin;
    logic              dc_skip;

    logic [MAGW-1:0]   peak_mag;
    logic [LOGPTS-1:0] peak_bin;
    logic [SUMW-1:0]   sum_mag;
    logic [EXPW-1:0]   frame_exp;

    logic              read_outp;
    logic              peak_valid;
    logic [LOGPTS-1:0] out_bin;
    logic [MAGW-1:0]   out_mag;
    logic [SUMW-1:0]   out_sum;
    logic [EXPW-1:0]   out_exp;
    logic              err;

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_READ;
            ST_READ: begin
                if (last_beat)    state_d = ST_DRAIN;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_DRAIN:  if (drain_done) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start      = (state_q == ST_IDLE) && bus.ENABLE && bus.OUTP_READY;
        beat       = (state_q == ST_READ) && bus.DATAO_VALID;
        last_beat  = beat && (bin_cnt == LOGPTS'(POINTS - 1));
        timeout    = (state_q == ST_READ) && !bus.DATAO_VALID &&
                     (idle_cnt == IDLEW'(TIMEOUT - 1));
        drain_done = (state_q == ST_DRAIN) && (drain_cnt == 2'(MAG_PIPE - 1));
        report     = (state_q == ST_REPORT);
        in_frame   = (state_q == ST_READ) || (state_q == ST_DRAIN);
    end

    fft_inpl_mag2 #(
        .WIDTH (WIDTH),
        .BINW  (LOGPTS)
    ) u_mag2 (
        .clk        (CLK),
        .rst_n      (NGRST),
        .beat_valid (beat),
        .re         (bus.DATAO_RE),
        .im         (bus.DATAO_IM),
        .bin        (bin_cnt),
        .mag_valid  (mag_valid),
        .mag        (mag),
        .mag_bin    (mag_bin)
    );

    assign dc_skip = (SKIP_DC != 0) && (mag_bin == '0);

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            bin_cnt   <= '0;
            idle_cnt  <= '0;
            drain_cnt <= '0;
            read_outp <= 1'b0;
            frame_exp <= '0;
        end else begin
            if (start) begin
                bin_cnt   <= '0;
                idle_cnt  <= '0;
                read_outp <= 1'b1;
                frame_exp <= bus.SCALE_EXP;
            end else if (state_q == ST_READ) begin
                if (beat) begin
                    bin_cnt  <= bin_cnt + LOGPTS'(1);
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IDLEW'(1);
                end
                if (last_beat || timeout) read_outp <= 1'b0;
            end
            if (last_beat)                 drain_cnt <= '0;
            else if (state_q == ST_DRAIN)  drain_cnt <= drain_cnt + 2'd1;
        end
    end

    // Peak starts at zero on the first searchable bin, so an all-zero frame
    // reports that bin; strict '>' keeps the lowest index on ties.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            peak_mag <= '0;
            peak_bin <= '0;
            sum_mag  <= '0;
        end else if (start) begin
            peak_mag <= '0;
            peak_bin <= FIRST_BIN;
            sum_mag  <= '0;
        end else if (mag_valid && in_frame) begin
            sum_mag <= sum_mag + SUMW'(mag);
            if (!dc_skip && (mag > peak_mag)) begin
                peak_mag <= mag;
                peak_bin <= mag_bin;
            end
        end
    end

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            peak_valid <= 1'b0;
            out_bin    <= '0;
            out_mag    <= '0;
            out_sum    <= '0;
            out_exp    <= '0;
            err        <= 1'b0;
        end else begin
            peak_valid <= report;
            if (report) begin
                out_bin <= peak_bin;
                out_mag <= peak_mag;
                out_sum <= sum_mag;
                out_exp <= frame_exp;
            end
            if (timeout) err <= 1'b1;
        end
    end

    assign bus.READ_OUTP  = read_outp;
    assign bus.PEAK_VALID = peak_valid;
    assign bus.PEAK_BIN   = out_bin;
    assign bus.PEAK_MAG   = out_mag;
    assign bus.SUM_MAG    = out_sum;
    assign bus.PEAK_EXP   = out_exp;
    assign bus.ERR        = err;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fft_inpl_peak_search.sv
// Directed bench for fft_inpl_peak_search: hand-computed frames, a result
// scoreboard fed by a PEAK_VALID monitor, timeout and mid-frame reset cases.
module tb_fft_inpl_peak_search;
    import fft_inpl_pkg::*;

    localparam int POINTS  = 256;
    localparam int WIDTH   = 18;
    localparam int EXPW    = 4;
    localparam int LOGPTS  = 8;
    localparam int TIMEOUT = 1023;
    localparam int RW      = LOGPTS + 2*WIDTH + 2*WIDTH + LOGPTS + EXPW;

    logic CLK;
    logic NGRST;

    fft_inpl_peak_search_if #(.WIDTH(WIDTH), .EXPW(EXPW), .LOGPTS(LOGPTS)) bus ();

    fft_inpl_peak_search #(
        .POINTS  (POINTS),
        .WIDTH   (WIDTH),
        .EXPW    (EXPW),
        .SKIP_DC (1),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .NGRST (NGRST),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic signed [WIDTH-1:0] re_tab[POINTS];
    logic signed [WIDTH-1:0] im_tab[POINTS];
    logic [RW-1:0]           exp_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < POINTS; i++) begin
            re_tab[i] = '0;
            im_tab[i] = '0;
        end
    endtask

    function automatic logic [RW-1:0] pack_res(input int bin, input longint mag,
                                               input longint sum, input int e);
        logic [RW-1:0] r;
        r = {LOGPTS'(bin), (2*WIDTH)'(mag), (2*WIDTH+LOGPTS)'(sum), EXPW'(e)};
        return r;
    endfunction

    // Waits (bounded) for the read request, then streams n_beats bins back to back.
    task automatic send_frame(input int n_beats, input logic drop_req);
        int guard;
        guard = 0;
        while ((bus.READ_OUTP !== 1'b1) && (guard < 50)) begin
            @(negedge CLK);
            guard++;
        end
        check("read_outp_rise", 64'(bus.READ_OUTP), 64'(1));
        if (drop_req) begin
            bus.ENABLE     = 1'b0;
            bus.OUTP_READY = 1'b0;
        end
        for (int i = 0; i < n_beats; i++) begin
            bus.DATAO_VALID = 1'b1;
            bus.DATAO_RE    = re_tab[i];
            bus.DATAO_IM    = im_tab[i];
            @(negedge CLK);
        end
        bus.DATAO_VALID = 1'b0;
        bus.DATAO_RE    = '0;
        bus.DATAO_IM    = '0;
    endtask

    task automatic settle(input string tag);
        repeat (12) @(negedge CLK);
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge CLK) begin
        if (bus.PEAK_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(1), 64'(0));
            end else begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                check("peak_bin", 64'(bus.PEAK_BIN), 64'(e[RW-1 -: LOGPTS]));
                check("peak_mag", 64'(bus.PEAK_MAG), 64'(e[RW-LOGPTS-1 -: 2*WIDTH]));
                check("sum_mag",  64'(bus.SUM_MAG),  64'(e[EXPW +: 2*WIDTH+LOGPTS]));
                check("peak_exp", 64'(bus.PEAK_EXP), 64'(e[EXPW-1:0]));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        NGRST           = 1'b0;
        bus.ENABLE      = 1'b0;
        bus.OUTP_READY  = 1'b0;
        bus.DATAO_VALID = 1'b0;
        bus.DATAO_RE    = '0;
        bus.DATAO_IM    = '0;
        bus.SCALE_EXP   = '0;
        clear_tab();
        repeat (3) @(negedge CLK);
        NGRST = 1'b1;
        @(negedge CLK);

        check("rst_read_outp",  64'(bus.READ_OUTP),  64'(0));
        check("rst_peak_valid", 64'(bus.PEAK_VALID), 64'(0));
        check("rst_peak_bin",   64'(bus.PEAK_BIN),   64'(0));
        check("rst_peak_mag",   64'(bus.PEAK_MAG),   64'(0));
        check("rst_sum_mag",    64'(bus.SUM_MAG),    64'(0));
        check("rst_peak_exp",   64'(bus.PEAK_EXP),   64'(0));
        check("rst_err",        64'(bus.ERR),        64'(0));
        check("rst_state",      64'(bus.dbg_state),  64'(ST_IDLE));

        // 1: single tone at bin 5; ENABLE/OUTP_READY dropped mid-frame
        clear_tab();
        re_tab[5] = 18'sd1000;
        bus.SCALE_EXP  = 4'd1;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        exp_q.push_back(pack_res(5, 1000000, 1000000, 1));
        send_frame(POINTS, 1'b1);
        check("t1_read_outp_after_last", 64'(bus.READ_OUTP), 64'(0));
        check("t1_state_drain",          64'(bus.dbg_state), 64'(ST_DRAIN));
        settle("t1_pending");
        check("t1_state_idle", 64'(bus.dbg_state), 64'(ST_IDLE));

        // 2: tie at bins 7 and 200, large DC excluded from peak but summed
        clear_tab();
        re_tab[7]   = 18'sd20;
        im_tab[200] = -18'sd20;
        re_tab[0]   = 18'sd50;
        im_tab[0]   = 18'sd50;
        bus.SCALE_EXP  = 4'd0;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        exp_q.push_back(pack_res(7, 400, 5800, 0));
        send_frame(POINTS, 1'b1);
        settle("t2_pending");

        // 3: full-scale negative samples in every bin
        for (int i = 0; i < POINTS; i++) begin
            re_tab[i] = 18'h20000;
            im_tab[i] = 18'h20000;
        end
        bus.SCALE_EXP  = 4'd7;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        exp_q.push_back(pack_res(1, 64'd34359738368, 64'd8796093022208, 7));
        send_frame(POINTS, 1'b1);
        settle("t3_pending");

        // 5: back-to-back frames, exponent changes between them
        clear_tab();
        re_tab[10] = 18'sd3;
        im_tab[10] = 18'sd4;
        bus.SCALE_EXP  = 4'd2;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        exp_q.push_back(pack_res(10, 25, 25, 2));
        exp_q.push_back(pack_res(255, 49, 49, 3));
        send_frame(POINTS, 1'b0);
        bus.SCALE_EXP = 4'd3;
        clear_tab();
        re_tab[255] = -18'sd7;
        send_frame(POINTS, 1'b1);
        settle("t5_pending");

        // 4: frame stalls after 100 beats
        clear_tab();
        re_tab[3] = 18'sd9;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        check("t4_err_before", 64'(bus.ERR), 64'(0));
        send_frame(100, 1'b1);
        cnt = 0;
        while ((bus.ERR !== 1'b1) && (cnt < TIMEOUT + 100)) begin
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
        end
        check("t4_timeout_cycles", 64'(cnt),            64'(TIMEOUT));
        check("t4_err",            64'(bus.ERR),        64'(1));
        check("t4_read_outp",      64'(bus.READ_OUTP),  64'(0));
        check("t4_state_idle",     64'(bus.dbg_state),  64'(ST_IDLE));
        repeat (5) begin
            bus.DATAO_VALID = 1'b1;
            bus.DATAO_RE    = 18'sd100;
            @(negedge CLK);
        end
        bus.DATAO_VALID = 1'b0;
        bus.DATAO_RE    = '0;
        check("t4_stray_beats_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        settle("t4_no_strobe");
        check("t4_err_sticky", 64'(bus.ERR), 64'(1));

        // 6: reset in the middle of a read, then a clean frame
        clear_tab();
        re_tab[20] = 18'sd500;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        send_frame(50, 1'b1);
        #2;
        NGRST = 1'b0;
        #1;
        check("t6_rst_read_outp", 64'(bus.READ_OUTP), 64'(0));
        check("t6_rst_err",       64'(bus.ERR),       64'(0));
        check("t6_rst_peak_mag",  64'(bus.PEAK_MAG),  64'(0));
        check("t6_rst_sum_mag",   64'(bus.SUM_MAG),   64'(0));
        check("t6_rst_peak_exp",  64'(bus.PEAK_EXP),  64'(0));
        check("t6_rst_state",     64'(bus.dbg_state), 64'(ST_IDLE));
        @(negedge CLK);
        NGRST = 1'b1;
        @(negedge CLK);
        clear_tab();
        re_tab[100] = -18'sd300;
        im_tab[100] = 18'sd400;
        bus.SCALE_EXP  = 4'd5;
        bus.ENABLE     = 1'b1;
        bus.OUTP_READY = 1'b1;
        exp_q.push_back(pack_res(100, 250000, 250000, 5));
        send_frame(POINTS, 1'b1);
        settle("t6_pending");
        check("t6_err_after", 64'(bus.ERR), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
